// File: rtl/apb_master_bridge_pkg.sv
// apb_master_bridge_pkg: shared state, command types and default widths for the APB requester.
package apb_master_bridge_pkg;
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;
endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command/response stream plus APB3 bus; master = bridge view, slave = environment view.
interface apb_master_bridge_if
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, psel, penable, pwrite, paddr, pwdata
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_bridge_timeout_cnt.sv
// apb_master_bridge_timeout_cnt: saturating ACCESS-phase wait counter; expired_o once the count equals limit_i.
module apb_master_bridge_timeout_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk)
        cnt_q <= (rst || clear_i) ? '0 : (enable_i && cnt_q != limit_i) ? cnt_q + W'(1) : cnt_q;
    assign expired_o = cnt_q == limit_i;
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB3 SETUP/ACCESS transfers with a one-cycle response strobe.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES cycles.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                 pclk,
    input logic                 rst,
    apb_master_bridge_if.master bus
);
    apb_state_t        state_q;
    logic              cmd_ready_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_slverr_q;
    logic              expired;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    apb_master_bridge_timeout_cnt #(.W(CNT_W)) u_timeout (
        .clk      (pclk),
        .rst      (rst),
        .clear_i  (state_q == SETUP),
        .enable_i (state_q == ACCESS && !bus.pready),
        .limit_i  (CNT_W'(TIMEOUT_CYCLES - 1)),
        .expired_o(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= !(bus.cmd_valid && cmd_ready_q);
                    if (bus.cmd_valid && cmd_ready_q) begin
                        state_q  <= SETUP;
                        psel_q   <= 1'b1;
                        pwrite_q <= bus.cmd_write;
                        paddr_q  <= bus.cmd_addr;
                        pwdata_q <= bus.cmd_wdata;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    // pready outranks a timeout landing in the same cycle
                    if (bus.pready || expired) begin
                        state_q      <= IDLE;
                        cmd_ready_q  <= 1'b1;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_slverr_q <= bus.pready ? bus.pslverr : 1'b1;
                        rsp_rdata_q  <= (bus.pready && !pwrite_q) ? bus.prdata : '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_slverr = rsp_slverr_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench with a behavioural APB slave and bus protocol monitor.
module tb_apb_master_bridge;
    import apb_master_bridge_pkg::*;
    localparam int NEVER = 1_000_000;
    localparam int TO    = 16;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    apb_master_bridge_if bus ();
    apb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (.pclk(pclk), .rst(rst), .bus(bus));

    int checks = 0, errors = 0;
    int cyc = 0, setup_cyc = 0, prev_setup = -1, setups = 0, wcnt = 0, wait_cfg = 0;
    logic        err_cfg = 1'b0, chk_spacing = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [40:0] cap;
    exp_t        sb [$];
    apb_cmd_t    cq [$];
    exp_t        me;
    apb_cmd_t    mc;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // slave model and protocol monitor, mid-cycle
    always @(negedge pclk) begin
        cyc++;
        check("pen_wo_psel", 64'(bus.penable & ~bus.psel), 0);
        if (bus.psel && !bus.penable) begin
            if (chk_spacing && prev_setup >= 0) check("spacing", 64'(cyc - prev_setup), 3);
            prev_setup = cyc;
            setup_cyc  = cyc;
            setups++;
            wcnt = 0;
            cap  = {bus.paddr, bus.pwrite, bus.pwdata};
            if (cq.size() == 0) check("setup_unexp", 1, 0);
            else begin
                mc = cq.pop_front();
                check("paddr", 64'(bus.paddr), 64'(mc.addr));
                check("pwrite", 64'(bus.pwrite), 64'(mc.write));
                check("pwdata", 64'(bus.pwdata), 64'(mc.wdata));
            end
        end
        if (bus.psel && bus.penable) begin
            check("stable", 64'({bus.paddr, bus.pwrite, bus.pwdata}), 64'(cap));
            bus.pready  = wcnt >= wait_cfg;
            bus.pslverr = bus.pready & err_cfg;
            bus.prdata  = bus.pwrite ? 32'hDEAD_BEEF : mem[bus.paddr];
            if (bus.pready && bus.pwrite) mem[bus.paddr] = bus.pwdata;
            wcnt++;
        end else begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            bus.prdata  = 32'hDEAD_BEEF;
        end
        if (bus.rsp_valid) begin
            if (sb.size() == 0) check("rsp_unexp", 1, 0);
            else begin
                me = sb.pop_front();
                check("rsp_rdata", 64'(bus.rsp_rdata), 64'(me.rdata));
                check("rsp_slverr", 64'(bus.rsp_slverr), 64'(me.err));
                check("rsp_lat", 64'(cyc - setup_cyc), 64'(me.lat));
                check("psel_gap", 64'(bus.psel), 0);
            end
        end
    end

    task automatic send(logic w, logic [7:0] a, logic [31:0] d, int waits, logic err, logic to);
        exp_t     e;
        apb_cmd_t c;
        bit       acc = 0;
        c.write = w; c.addr = a; c.wdata = d;
        cq.push_back(c);
        e.rdata = (w || to) ? 32'd0 : ref_mem[a];
        e.err   = err || to;
        e.lat   = to ? TO + 1 : waits + 2;
        sb.push_back(e);
        if (w) ref_mem[a] = d;
        wait_cfg = to ? NEVER : waits;
        err_cfg  = err;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = bus.cmd_ready;
            @(posedge pclk);
            #1;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge pclk);
        check("drain", 64'(sb.size()), 0);
        @(posedge pclk);
        #1;
    endtask

    task automatic chk_reset(string ph);
        check({ph, "_psel"}, 64'(bus.psel), 0);
        check({ph, "_penable"}, 64'(bus.penable), 0);
        check({ph, "_pwrite"}, 64'(bus.pwrite), 0);
        check({ph, "_paddr"}, 64'(bus.paddr), 0);
        check({ph, "_pwdata"}, 64'(bus.pwdata), 0);
        check({ph, "_rsp_valid"}, 64'(bus.rsp_valid), 0);
        check({ph, "_rsp_rdata"}, 64'(bus.rsp_rdata), 0);
        check({ph, "_rsp_slverr"}, 64'(bus.rsp_slverr), 0);
        check({ph, "_cmd_ready"}, 64'(bus.cmd_ready), 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i * 3 + 1);
            ref_mem[i] = 32'(i * 3 + 1);
        end
        repeat (3) @(posedge pclk);
        #1;
        chk_reset("rst0");
        rst = 1'b0;
        @(posedge pclk);
        #1;
        check("ready_after_rst", 64'(bus.cmd_ready), 1);
        // zero-wait write then read-back
        send(1'b1, 8'd2, 32'd16, 0, 1'b0, 1'b0);
        send(1'b0, 8'd2, 32'h5555_0000, 0, 1'b0, 1'b0);
        drain();
        // three wait states on a write
        send(1'b1, 8'd4, 32'd32, 3, 1'b0, 1'b0);
        drain();
        // slave error on a read
        send(1'b0, 8'd8, 32'h0, 0, 1'b1, 1'b0);
        drain();
        // back-to-back with cmd_valid held
        chk_spacing = 1'b1;
        prev_setup  = -1;
        setups      = 0;
        send(1'b1, 8'd2, 32'hA5A5_0001, 0, 1'b0, 1'b0);
        send(1'b0, 8'd4, 32'h0, 0, 1'b0, 1'b0);
        send(1'b0, 8'd8, 32'h0, 0, 1'b0, 1'b0);
        drain();
        chk_spacing = 1'b0;
        check("b2b_setups", 64'(setups), 3);
        // reset during a stalled read
        send(1'b0, 8'd8, 32'h0, NEVER, 1'b0, 1'b0);
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("stalled_penable", 64'(bus.penable), 1);
        rst = 1'b1;
        @(posedge pclk);
        #1;
        sb.delete();
        chk_reset("rst_mid");
        rst      = 1'b0;
        wait_cfg = 0;
        @(posedge pclk);
        #1;
        check("ready_after_mid_rst", 64'(bus.cmd_ready), 1);
        repeat (3) @(posedge pclk);
        #1;
        send(1'b0, 8'd4, 32'h0, 1, 1'b0, 1'b0);
        drain();
`ifdef APB_MASTER_TIMEOUT_EN
        send(1'b0, 8'd4, 32'h0, 0, 1'b0, 1'b1);
        drain();
        send(1'b0, 8'd4, 32'h0, TO - 1, 1'b0, 1'b0);
        drain();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Synthesizable APB3 requester. Converts a simple valid/ready command stream into APB SETUP/ACCESS transfers, then returns read data and error status on a one-cycle response strobe.
- Sits between internal control logic and the apb_if bus. It is the RTL counterpart of apb_slave and replaces the behavioural writeData/readData tasks in system-level benches.

Parameters:
- ADDR_W, 8: width of paddr and cmd_addr.
- DATA_W, 32: width of pwdata, prdata, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16: ACCESS-phase cycles allowed before abort. Used only with APB_MASTER_TIMEOUT_EN.

Ports:
- pclk  in  1  APB clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse: transfer complete.
- rsp_rdata  out  DATA_W  read data; zero for writes.
- rsp_slverr  out  1  slave error or timeout; qualified by rsp_valid.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  slave ready.
- pslverr  in  1  slave error.

Behaviour:
- Reset (rst=1 at a pclk edge):
  - State returns to IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_slverr all go to 0. cmd_ready goes to 0 during reset.
  - Reset mid-transfer abandons the transfer immediately. No response is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid and cmd_ready: capture cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata, then go to SETUP.
- SETUP: psel=1, penable=0, cmd_ready=0. Unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1, cmd_ready=0.
  - pready=0: stay in ACCESS (wait states are unbounded unless the optional feature is enabled).
  - pready=1: go to IDLE. On the next cycle rsp_valid=1 and rsp_slverr=pslverr; rsp_rdata=prdata for reads, 0 for writes.
- Latency: command accepted at edge N gives SETUP at N+1, ACCESS at N+2. With zero wait states, rsp_valid is high in the cycle after edge N+3. Minimum spacing between transfers is 3 cycles.
- Bus stability: paddr, pwrite and pwdata hold constant from SETUP through the final ACCESS cycle. They keep their last values in IDLE, but psel=0 there.
- Between transfers psel=0 and penable=0. penable is never 1 without psel.
- rsp_valid has no backpressure and lasts exactly one cycle. rsp_rdata and rsp_slverr hold until the next response.
- cmd_valid outside IDLE is ignored. The command source must hold its command until cmd_ready.
- Simultaneous events: rsp_valid and cmd_ready are both high in the cycle after completion. A command accepted in that cycle is legal.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES-1 without pready, the transfer aborts: go to IDLE, rsp_valid=1, rsp_slverr=1, rsp_rdata=0.
  - If pready arrives in the same cycle as the limit, pready wins.
- Undefined: no counter logic; wait states are unbounded.

Decomposition:
- Add to definesPkg:
  - apb_state_t enum {IDLE, SETUP, ACCESS}.
  - apb_cmd_t packed struct {write, addr, wdata}.
  - APB_ADDR_W=8 and APB_DATA_W=32 as defaults.
- Optional sub-module apb_timeout_cnt: clear/enable/limit inputs, expired output. Instantiated only under the macro.

Test Plan:
- Write then read with zero wait states: write addr 2, data 16, then read addr 2 with slave returning 16. Expect rsp_rdata=16, rsp_slverr=0, and SETUP→ACCESS→rsp spacing of exactly 1/1/1 cycles.
- Wait states: pready held low 3 ACCESS cycles on a write to addr 4, data 32. Expect psel/penable/paddr/pwdata stable for 4 ACCESS cycles and rsp_valid one cycle after pready.
- Slave error: pslverr=1 with pready on a read of addr 8. Expect rsp_slverr=1 for one rsp_valid pulse.
- Back-to-back: cmd_valid held high for 3 commands (addrs 2, 4, 8). Expect exactly one SETUP per command, psel low between transfers, and 3-cycle spacing.
- Reset mid-ACCESS: rst asserted during a stalled read. Expect all outputs 0 the next cycle, no rsp_valid, and cmd_ready=1 after rst drops.
- Timeout (macro defined, TIMEOUT_CYCLES=16): pready never asserts. Expect abort after 16 ACCESS cycles with rsp_slverr=1 and rsp_rdata=0.
